// File: rtl/mdu_unit.sv
// Multiply/divide unit for the Execute stage: owns HI/LO, models fixed
// multi-cycle latency with a countdown, and raises the Decode stall request.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        d_mlu_use,
    output logic        mdu_start,
    output logic        mdu_busy,
    output logic        mdu_stall,
    output logic [31:0] mdu_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic [3:0]  r_cnt;
    logic [31:0] r_hi, r_lo, r_hi_n, r_lo_n;

    logic        w_is_mult, w_accept;
    logic [63:0] w_a_ext, w_b_ext, w_prod;
    logic        w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag, w_b_safe, w_q_mag, w_r_mag, w_quot, w_rem;
    logic [31:0] w_res_hi, w_res_lo;

    assign mdu_start = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU) ||
                       (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
    assign mdu_busy  = (r_cnt != 4'd0);
    assign mdu_stall = d_mlu_use & (mdu_start | mdu_busy);
    assign w_is_mult = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
    assign w_accept  = mdu_start & ~mdu_busy;

    // Sign- or zero-extend to 64 bits so one truncated multiply serves both forms.
    assign w_a_ext = {((mdu_op == OP_MULT) ? {32{A[31]}} : 32'd0), A};
    assign w_b_ext = {((mdu_op == OP_MULT) ? {32{B[31]}} : 32'd0), B};
    assign w_prod  = w_a_ext * w_b_ext;

    // Divide on magnitudes and restore signs; this also makes INT_MIN / -1
    // wrap to INT_MIN with a zero remainder.
    assign w_a_neg  = (mdu_op == OP_DIV) & A[31];
    assign w_b_neg  = (mdu_op == OP_DIV) & B[31];
    assign w_a_mag  = w_a_neg ? -A : A;
    assign w_b_mag  = w_b_neg ? -B : B;
    assign w_b_safe = (B == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag  = w_a_mag / w_b_safe;
    assign w_r_mag  = w_a_mag % w_b_safe;
    assign w_quot   = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    assign w_rem    = w_a_neg ? -w_r_mag : w_r_mag;

    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        if (w_is_mult) begin
            w_res_hi = w_prod[63:32];
            w_res_lo = w_prod[31:0];
        end else if (B != 32'd0) begin
            w_res_hi = w_rem;
            w_res_lo = w_quot;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= 4'd0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_hi_n <= 32'd0;
            r_lo_n <= 32'd0;
        end else if (mdu_busy) begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
                r_hi <= r_hi_n;
                r_lo <= r_lo_n;
            end
        end else begin
            if (w_accept) begin
                r_hi_n <= w_res_hi;
                r_lo_n <= w_res_lo;
                r_cnt  <= w_is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            end
            if (mdu_op == OP_MTHI) r_hi <= A;
            if (mdu_op == OP_MTLO) r_lo <= A;
        end
    end

    always_comb begin
        mdu_rdata = 32'd0;
        if (mdu_op == OP_MFHI) mdu_rdata = r_hi;
        else if (mdu_op == OP_MFLO) mdu_rdata = r_lo;
    end

    assign hi = r_hi;
    assign lo = r_lo;
endmodule

// File: doc/mdu_unit.md
# mdu_unit

Multiply/divide unit for the five-stage MIPS pipeline, sitting in the Execute stage alongside the ALU. It serves the instructions that the Decode stage flags via `mlu_use` (mult, multu, div, divu, mfhi, mflo, mthi, mtlo). It holds the HI/LO registers, models fixed multi-cycle latency with a busy counter, and produces the stall request that holds a `mlu_use` instruction in Decode while the unit is starting or busy.

## Interface
- `MULT_CYCLES`, default 5: busy duration in cycles for mult/multu; legal range 1–15.
- `DIV_CYCLES`, default 10: busy duration in cycles for div/divu; legal range 1–15.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `mdu_op` input 4: operation of the instruction currently in Execute.
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
  - 9–15 are treated as none.
- `A` input 32: forwarded rs value (multiplicand or dividend; source for mthi/mtlo).
- `B` input 32: forwarded rt value (multiplier or divisor).
- `d_mlu_use` input 1: the Decode-stage instruction uses the MDU.
- `mdu_start` output 1: combinational; 1 when `mdu_op` ∈ {1,2,3,4}.
- `mdu_busy` output 1: registered; 1 while an operation is in flight.
- `mdu_stall` output 1: combinational; `d_mlu_use & (mdu_start | mdu_busy)`.
- `mdu_rdata` output 32: combinational.
  - HI when op=5, LO when op=6, else 0.
  - Always reads the committed HI/LO.
- `hi`, `lo` output 32 each: committed HI/LO registers, for debug and verification.

## Operation
- State: committed `hi` and `lo`; shadow registers `hi_n` and `lo_n`; 4-bit `cnt`. `mdu_busy = (cnt != 0)`.
- Idle, start op accepted (`mdu_start & ~mdu_busy`):
  - Compute the result from A and B and capture it into `hi_n`/`lo_n`.
  - Load `cnt` with MULT_CYCLES (ops 1–2) or DIV_CYCLES (ops 3–4).
- mult: signed 32×32→64. multu: unsigned. `hi_n` = product[63:32], `lo_n` = product[31:0].
- div/divu:
  - `lo_n` = quotient; `hi_n` = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - A divisor of 0 leaves the shadow equal to the current committed `hi`/`lo`, so HI/LO are unchanged at commit.
- Busy: `cnt` decrements each cycle. At the edge where `cnt`==1, `hi`←`hi_n`, `lo`←`lo_n`, and `cnt` becomes 0.
- mthi/mtlo when not busy: `hi` (resp. `lo`) ← A at the edge. They do not touch `cnt`.
- Any start, mthi or mtlo presented while `mdu_busy`=1 is ignored: no state change. The pipeline guarantees this cannot happen through `mdu_stall`.
- mfhi/mflo have no side effects.

## Timing
- Reset: asynchronous; effective immediately, independent of `clk`.
  - `hi`=`lo`=`hi_n`=`lo_n`=0, `cnt`=0, `mdu_busy`=0.
  - Reset mid-operation discards the in-flight result with no commit.
- Start sampled in cycle T:
  - `mdu_busy`=1 in cycles T+1 … T+N, where N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO commit at the edge closing cycle T+N; new values are visible and `mdu_busy`=0 from cycle T+N+1.
- mfhi issued in cycle T+N+1 returns the new HI combinationally in that cycle.
- `mdu_stall` is high in cycle T when a `mlu_use` instruction sits in Decode. It stays high through T+N, so that instruction enters Execute at T+N+1 at the earliest.
- Back-to-back starts: a second start op in Execute at T+N+1 is accepted and reloads `cnt`. There is no gap requirement beyond that.
- mthi/mtlo in cycle T: written at the edge closing T; visible to mfhi/mflo from T+1.

## Test plan
- Reset mid-operation:
  - mult A=3, B=5, then assert `reset` in the 3rd busy cycle.
  - Required: busy drops immediately, hi=lo=0, and no commit follows.
- Signed mult latency:
  - mult A=0xFFFFFFFE (−2), B=3 at T.
  - Required: busy T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- multu:
  - multu A=0xFFFFFFFF, B=2.
  - Required: hi=1, lo=0xFFFFFFFE after 5 busy cycles.
- Signed div, overflow and divide-by-zero:
  - div A=−7, B=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF after exactly 10 busy cycles.
  - div 0x80000000/−1: lo=0x80000000, hi=0.
  - divu with B=0 after mthi 0x11 and mtlo 0x22: hi=0x11, lo=0x22 unchanged.
- Stall handshake:
  - div at T with `d_mlu_use`=1 held.
  - Required: `mdu_stall`=1 in T..T+10 and 0 in T+11.
  - Required: a start op forced while busy leaves `cnt`/`hi_n` untouched.
- Move and read path:
  - mthi A=0xDEADBEEF, then mfhi next cycle: `mdu_rdata`=0xDEADBEEF.
  - mflo with op=6 reads lo.
  - op=0 or 12 gives `mdu_rdata`=0 and `mdu_start`=0.
